reg_bridge: RTL

//  Host-side command sequencer directly upstream of the top-level register port.
//  - Accepts queued host read/write commands over a valid/ready handshake.
//  - Drives the 2-bit ctl / 32-bit addr / 32-bit data register interface, one operation at a time.
//  - Captures read data and returns one response per command over a valid/ready handshake.

---
 rtl/reg_bridge_pkg.sv | 34 +++
 rtl/reg_bridge_cmd_fifo.sv | 62 ++++++
 rtl/reg_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_bridge_pkg.sv
// Shared definitions for reg_bridge: register-port opcodes, FSM encoding, command record.
// The command record grows by one poll bit when REG_BRIDGE_POLL_EN is defined.
package reg_bridge_pkg;

  localparam logic [1:0] CTL_NOP   = 2'h0;
  localparam logic [1:0] CTL_READ  = 2'h1;
  localparam logic [1:0] CTL_WRITE = 2'h2;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
`ifdef REG_BRIDGE_POLL_EN
    logic              poll;
`endif
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [1:0] op_ctl(input logic write);
    return write ? CTL_WRITE : CTL_READ;
  endfunction

endpackage

// File: rtl/reg_bridge_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; head visible combinationally, 1-cycle write-to-read.
// Backpressure: o_full blocks pushes; pointers carry an extra wrap bit.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/reg_bridge.sv
// Host command sequencer onto the ctl/addr/data register port; one op in flight, write rsp at N+3, read at N+3+RD_LAT.
// Commands stall when the FIFO is full; a response holds until i_rsp_ready. Poll reads with REG_BRIDGE_POLL_EN.
module reg_bridge
  import reg_bridge_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RD_LAT   = 1,
  parameter int POLL_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
`ifdef REG_BRIDGE_POLL_EN
  input  logic              i_cmd_poll,
  output logic              o_rsp_tmo,
`endif
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_write,
  output logic [1:0]        o_reg_ctl,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_data,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic              o_busy
);

  cmd_t             cmd_in;
  cmd_t             cmd_head;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_write_q, rsp_write_d;

`ifdef REG_BRIDGE_POLL_EN
  localparam int PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           rsp_tmo_q, rsp_tmo_d;
`endif

  always_comb begin
    cmd_in       = '0;
    cmd_in.write = i_cmd_write;
    cmd_in.addr  = i_cmd_addr;
    cmd_in.data  = i_cmd_data;
`ifdef REG_BRIDGE_POLL_EN
    cmd_in.poll  = i_cmd_poll;
`endif
  end

  assign cmd_head = cmd_t'(fifo_dout);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_din   (cmd_in),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    ctl_d       = CTL_NOP;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    fifo_pop    = 1'b0;
`ifdef REG_BRIDGE_POLL_EN
    poll_cnt_d  = poll_cnt_q;
    rsp_tmo_d   = rsp_tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = cmd_head;
          state_d  = ST_ISSUE;
`ifdef REG_BRIDGE_POLL_EN
          poll_cnt_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
        ctl_d   = op_ctl(cmd_q.write);
        addr_d  = cmd_q.addr;
        wdata_d = cmd_q.data;
        if (cmd_q.write) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
`ifdef REG_BRIDGE_POLL_EN
          if (cmd_q.poll && !i_reg_data[0] && (poll_cnt_q != PCW'(POLL_MAX))) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            rsp_data_d  = i_reg_data;
            rsp_write_d = 1'b0;
            rsp_tmo_d   = cmd_q.poll && !i_reg_data[0];
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
`else
          rsp_data_d  = i_reg_data;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`endif
        end
      end
      ST_RESP: begin
        // Writes arrive here without a response yet; reads arrive with it already raised.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_write_d = 1'b1;
`ifdef REG_BRIDGE_POLL_EN
          rsp_tmo_d   = 1'b0;
`endif
        end else if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      ctl_q       <= CTL_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
`ifdef REG_BRIDGE_POLL_EN
      poll_cnt_q  <= '0;
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      ctl_q       <= ctl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
`ifdef REG_BRIDGE_POLL_EN
      poll_cnt_q  <= poll_cnt_d;
      rsp_tmo_q   <= rsp_tmo_d;
`endif
    end
  end

  assign o_cmd_ready = !fifo_full;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_write = rsp_write_q;
  assign o_reg_ctl   = ctl_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_data  = wdata_q;
  assign o_busy      = !fifo_empty || (state_q != ST_IDLE);
`ifdef REG_BRIDGE_POLL_EN
  assign o_rsp_tmo   = rsp_tmo_q;
`endif

endmodule
